// File: rtl/vga_plot_arbiter_pkg.sv
// Shared game-display constants and the arbiter's state/owner types.
// Cell geometry and colour width default the plot arbiter parameters.
package vga_plot_arbiter_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COL_W    = 3;
    localparam int DEF_BLK_LOG2 = 1;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_SNAKE,
        OWN_FOOD
    } owner_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: pointer side wins a tie, pointer flips to the
// loser of the last granted decision whenever advance pulses.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt[ptr] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // After serving requester 0 the pointer favours 1, and vice versa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA pixel-write port between the snake and food drawers; each
// granted request plots one square cell, one pixel per cycle, then pulses done.
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COL_W    = DEF_COL_W,
    parameter int BLK_LOG2 = DEF_BLK_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_snake,
    input  logic [X_W-1:0]   x_snake,
    input  logic [Y_W-1:0]   y_snake,
    input  logic [COL_W-1:0] col_snake,
    input  logic             req_food,
    input  logic [X_W-1:0]   x_food,
    input  logic [Y_W-1:0]   y_food,
    input  logic [COL_W-1:0] col_food,
    output logic             gnt_snake,
    output logic             gnt_food,
    output logic             done_snake,
    output logic             done_food,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_plot,
    output logic             busy
);

    localparam int CNT_W = 2 * BLK_LOG2;

    state_t             state;
    owner_t             owner;
    logic [CNT_W-1:0]   pix_cnt;
    logic [X_W-1:0]     lx;
    logic [Y_W-1:0]     ly;
    logic [COL_W-1:0]   lcol;
    logic [1:0]         arb_gnt;
    logic               advance;
    logic               drawing;

    assign advance = (state == ST_IDLE) && (req_snake || req_food);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req_food, req_snake}),
        .advance (advance),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_SNAKE;
            pix_cnt <= '0;
            lx      <= '0;
            ly      <= '0;
            lcol    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        state   <= ST_DRAW;
                        pix_cnt <= '0;
                        if (arb_gnt[1]) begin
                            owner <= OWN_FOOD;
                            lx    <= x_food;
                            ly    <= y_food;
                            lcol  <= col_food;
                        end else begin
                            owner <= OWN_SNAKE;
                            lx    <= x_snake;
                            ly    <= y_snake;
                            lcol  <= col_snake;
                        end
                    end
                end
                ST_DRAW: begin
                    pix_cnt <= pix_cnt + 1'b1;
                    if (pix_cnt == '1) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Low counter bits step across the cell, high bits step down; sums wrap.
    assign drawing    = (state == ST_DRAW);
    assign vga_plot   = drawing;
    assign vga_x      = drawing ? lx + X_W'(pix_cnt[BLK_LOG2-1:0]) : '0;
    assign vga_y      = drawing ? ly + Y_W'(pix_cnt[CNT_W-1:BLK_LOG2]) : '0;
    assign vga_colour = drawing ? lcol : COL_W'(COL_BLACK);
    assign busy       = (state != ST_IDLE);
    assign gnt_snake  = busy && (owner == OWN_SNAKE);
    assign gnt_food   = busy && (owner == OWN_FOOD);
    assign done_snake = (state == ST_DONE) && (owner == OWN_SNAKE);
    assign done_food  = (state == ST_DONE) && (owner == OWN_FOOD);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, single cell, round-robin order,
// coordinate wrap, mid-draw request drop and mid-draw reset.
module tb_vga_plot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_snake, req_food;
    logic [7:0] x_snake, x_food;
    logic [6:0] y_snake, y_food;
    logic [2:0] col_snake, col_food;
    logic       gnt_snake, gnt_food, done_snake, done_food;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // {vga_plot, gnt_snake, gnt_food, done_snake, done_food, busy}
    logic [5:0]  st;
    logic [17:0] pix;
    assign st  = {vga_plot, gnt_snake, gnt_food, done_snake, done_food, busy};
    assign pix = {vga_x, vga_y, vga_colour};

    localparam logic [5:0] ST_IDLE_EXP  = 6'b000000;
    localparam logic [5:0] ST_DRAW_S    = 6'b110001;
    localparam logic [5:0] ST_DRAW_F    = 6'b101001;
    localparam logic [5:0] ST_DONE_S    = 6'b010101;
    localparam logic [5:0] ST_DONE_F    = 6'b001011;

    always #5 clk = ~clk;

    vga_plot_arbiter #(
        .X_W      (8),
        .Y_W      (7),
        .COL_W    (3),
        .BLK_LOG2 (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_snake  (req_snake),
        .x_snake    (x_snake),
        .y_snake    (y_snake),
        .col_snake  (col_snake),
        .req_food   (req_food),
        .x_food     (x_food),
        .y_food     (y_food),
        .col_food   (col_food),
        .gnt_snake  (gnt_snake),
        .gnt_food   (gnt_food),
        .done_snake (done_snake),
        .done_food  (done_food),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({st, pix} !== 24'd0) $display("FAIL reset_hold: got st=%b pix=%h want all 0", st, pix);
        else passed++;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({st, pix} !== 24'd0) $display("FAIL idle_%0d: got st=%b pix=%h want all 0", i, st, pix);
            else passed++;
        end
    endtask

    task automatic test_single_snake;
        logic [17:0] exp_pix;
        req_snake = 1'b1; x_snake = 8'd10; y_snake = 7'd20; col_snake = 3'b100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_pix = {8'd10 + 8'(k % 2), 7'd20 + 7'(k / 2), 3'b100};
            total++;
            if (st !== ST_DRAW_S) $display("FAIL single_st_%0d: got %b want %b", k, st, ST_DRAW_S);
            else passed++;
            total++;
            if (pix !== exp_pix) $display("FAIL single_pix_%0d: got %h want %h", k, pix, exp_pix);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (st !== ST_DONE_S) $display("FAIL single_done: got %b want %b", st, ST_DONE_S);
        else passed++;
        req_snake = 1'b0;
        @(negedge clk);
        total++;
        if (st !== ST_IDLE_EXP) $display("FAIL single_idle: got %b want %b", st, ST_IDLE_EXP);
        else passed++;
    endtask

    task automatic test_simultaneous;
        logic [17:0] exp_pix;
        logic        exp_food;
        // Fresh reset puts the pointer back on snake.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_snake = 1'b1; x_snake = 8'd0;  y_snake = 7'd0;  col_snake = 3'b001;
        req_food  = 1'b1; x_food  = 8'd50; y_food  = 7'd30; col_food  = 3'b010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_pix = {8'(k % 2), 7'(k / 2), 3'b001};
            total++;
            if ({st, pix} !== {ST_DRAW_S, exp_pix})
                $display("FAIL both_snake_%0d: got st=%b pix=%h want st=%b pix=%h", k, st, pix, ST_DRAW_S, exp_pix);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (st !== ST_DONE_S) $display("FAIL both_snake_done: got %b want %b", st, ST_DONE_S);
        else passed++;
        req_snake = 1'b0;
        @(negedge clk);
        total++;
        if (st !== ST_IDLE_EXP) $display("FAIL both_gap_idle: got %b want %b", st, ST_IDLE_EXP);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_pix = {8'd50 + 8'(k % 2), 7'd30 + 7'(k / 2), 3'b010};
            total++;
            if ({st, pix} !== {ST_DRAW_F, exp_pix})
                $display("FAIL both_food_%0d: got st=%b pix=%h want st=%b pix=%h", k, st, pix, ST_DRAW_F, exp_pix);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (st !== ST_DONE_F) $display("FAIL both_food_done: got %b want %b", st, ST_DONE_F);
        else passed++;
        req_food = 1'b0;
        @(negedge clk);

        // Pointer now on snake: four contested rounds go S, F, S, F.
        for (int r = 0; r < 4; r++) begin
            exp_food = (r % 2) == 1;
            req_snake = 1'b1;
            req_food  = 1'b1;
            @(posedge clk);
            #1;
            req_snake = 1'b0;
            req_food  = 1'b0;
            @(negedge clk);
            total++;
            if (st !== (exp_food ? ST_DRAW_F : ST_DRAW_S))
                $display("FAIL rr_round_%0d: got %b want %b", r, st, exp_food ? ST_DRAW_F : ST_DRAW_S);
            else passed++;
            repeat (4) @(negedge clk);
            total++;
            if (st !== (exp_food ? ST_DONE_F : ST_DONE_S))
                $display("FAIL rr_done_%0d: got %b want %b", r, st, exp_food ? ST_DONE_F : ST_DONE_S);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap;
        logic [17:0] exp_pix [4];
        exp_pix[0] = {8'd255, 7'd127, 3'b111};
        exp_pix[1] = {8'd0,   7'd127, 3'b111};
        exp_pix[2] = {8'd255, 7'd0,   3'b111};
        exp_pix[3] = {8'd0,   7'd0,   3'b111};
        req_food = 1'b1; x_food = 8'd255; y_food = 7'd127; col_food = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({st, pix} !== {ST_DRAW_F, exp_pix[k]})
                $display("FAIL wrap_%0d: got st=%b pix=%h want st=%b pix=%h", k, st, pix, ST_DRAW_F, exp_pix[k]);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (st !== ST_DONE_F) $display("FAIL wrap_done: got %b want %b", st, ST_DONE_F);
        else passed++;
        req_food = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_mid_draw;
        logic [17:0] exp_pix;
        req_snake = 1'b1; x_snake = 8'd4; y_snake = 7'd4; col_snake = 3'b010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_snake = 1'b0;
                x_snake   = 8'd99;
            end
            exp_pix = {8'd4 + 8'(k % 2), 7'd4 + 7'(k / 2), 3'b010};
            total++;
            if ({st, pix} !== {ST_DRAW_S, exp_pix})
                $display("FAIL drop_%0d: got st=%b pix=%h want st=%b pix=%h", k, st, pix, ST_DRAW_S, exp_pix);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (st !== ST_DONE_S) $display("FAIL drop_done: got %b want %b", st, ST_DONE_S);
        else passed++;
        @(negedge clk);
        total++;
        if (st !== ST_IDLE_EXP) $display("FAIL drop_idle: got %b want %b", st, ST_IDLE_EXP);
        else passed++;
    endtask

    task automatic test_reset_mid_draw;
        logic [17:0] exp_pix;
        req_snake = 1'b1; x_snake = 8'd60; y_snake = 7'd60; col_snake = 3'b100;
        @(negedge clk);
        total++;
        if (st !== ST_DRAW_S) $display("FAIL rstmid_pre: got %b want %b", st, ST_DRAW_S);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        req_snake = 1'b0;
        #1;
        total++;
        if ({st, pix} !== 24'd0) $display("FAIL rstmid_now: got st=%b pix=%h want all 0", st, pix);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({st, pix} !== 24'd0) $display("FAIL rstmid_hold_%0d: got st=%b pix=%h want all 0", i, st, pix);
            else passed++;
        end
        rst = 1'b1;
        req_food = 1'b1; x_food = 8'd30; y_food = 7'd40; col_food = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_pix = {8'd30 + 8'(k % 2), 7'd40 + 7'(k / 2), 3'b111};
            total++;
            if ({st, pix} !== {ST_DRAW_F, exp_pix})
                $display("FAIL rstmid_food_%0d: got st=%b pix=%h want st=%b pix=%h", k, st, pix, ST_DRAW_F, exp_pix);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (st !== ST_DONE_F) $display("FAIL rstmid_food_done: got %b want %b", st, ST_DONE_F);
        else passed++;
        req_food = 1'b0;
        @(negedge clk);
        total++;
        if (st !== ST_IDLE_EXP) $display("FAIL rstmid_idle: got %b want %b", st, ST_IDLE_EXP);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        req_snake = 1'b0; x_snake = '0; y_snake = '0; col_snake = '0;
        req_food  = 1'b0; x_food  = '0; y_food  = '0; col_food  = '0;
        @(negedge clk);
        test_reset();
        test_single_snake();
        test_simultaneous();
        test_wrap();
        test_drop_mid_draw();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
